ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline register for the pipelined core; sole consumer of the ALU's result/zero/overflow outputs.
//  Captures the ALU result and the EX control bundle and resolves BEQ/BNE from the ALU zero flag.
//  Raises a sticky overflow exception with PC and value capture.
//  Keeps performance counters for issued instructions and overflow events.
// PARAMETERS
//  XLEN        64  datapath width (ALU operand/result width)
//  REG_ADDR_W  5   destination register index width
//  CNT_W       32  performance counter width
// PORTS
//  clk            in   1           pipeline clock, rising edge
//  rst            in   1           asynchronous, active-high reset
//  stall          in   1           hold all MEM-side registers this cycle
//  flush          in   1           replace captured entry with bubble
//  ex_valid       in   1           EX stage holds a real instruction
//  ex_pc          in   XLEN        PC of EX instruction
//  alu_result     in   XLEN        ALU result
//  alu_zero       in   1           ALU zero flag
//  alu_overflow   in   1           ALU signed-overflow flag (ADD/SUB only)
//  ex_trap_en     in   1           overflow is an exception for this instruction
//  ex_rs2_data    in   XLEN        store data
//  ex_rd          in   REG_ADDR_W  destination register
//  ex_reg_write   in   1           ctrl: write rd
//  ex_mem_read    in   1           ctrl: load
//  ex_mem_write   in   1           ctrl: store
//  ex_mem_to_reg  in   1           ctrl: writeback selects memory data
//  ex_branch      in   1           conditional branch
//  ex_branch_ne   in   1           1 = BNE, 0 = BEQ
//  ex_br_target   in   XLEN        branch target address
//  exc_ack        in   1           clear pending exception
//  mem_valid, mem_pc, mem_alu_result, mem_store_data, mem_rd, mem_reg_write, mem_mem_read,
//  mem_mem_write, mem_mem_to_reg   out  (as EX widths)  registered copies
//  pc_src         out  1           one-cycle redirect pulse for a taken branch
//  br_target      out  XLEN        registered target, valid while pc_src=1
//  exc_pending    out  1           sticky overflow exception
//  exc_pc         out  XLEN        PC of faulting instruction
//  exc_value      out  XLEN        ALU result of faulting instruction
//  instr_cnt      out  CNT_W       count of valid entries captured
//  ovf_cnt        out  CNT_W       count of overflow exceptions raised
// BEHAVIOUR
//  Reset (async, immediate): every output = 0; state NORMAL.
//  Latency: 1 cycle, EX inputs -> mem_* outputs.
//  take = ex_valid & ex_branch & (alu_zero ^ ex_branch_ne).
//  trap = ex_valid & ex_trap_en & alu_overflow.
//  Per rising edge, priority order:
//   1 flush (overrides stall): bubble. mem_valid and all mem ctrl bits = 0, mem data = 0, pc_src = 0.
//     Counters unchanged. exc_* unaffected.
//   2 stall: all mem_* and br_target hold; pc_src forced 0 (the pulse never repeats); counters hold.
//   3 state EXC: any incoming instruction becomes a bubble (not counted).
//   4 NORMAL, trap: bubble captured, exc_pending=1, exc_pc=ex_pc, exc_value=alu_result,
//     ovf_cnt+1, state->EXC.
//   5 NORMAL, ex_valid: capture all fields, instr_cnt+1, pc_src=take, br_target=ex_br_target.
//   6 NORMAL, !ex_valid: bubble.
//  FSM NORMAL->EXC on trap (rule 4).
//   EXC->NORMAL on exc_ack: exc_pending=0 next cycle; exc_pc and exc_value hold their last value.
//   exc_ack in NORMAL is ignored. exc_ack and flush act independently in the same cycle.
//  First fault wins; no overwrite while pending.
//  Counters wrap modulo 2^CNT_W; no saturation.
//  Overflow on a non-trap instruction (ex_trap_en=0) is ignored; the result is captured normally.
//  A taken branch that also traps is a bubble: no redirect.
// TESTING
//  T1 reset mid-stream with mem_valid=1 -> all outputs 0 in the same cycle; instr_cnt=0.
//  T2 BEQ, alu_zero=1, ex_br_target=0x100 -> next cycle pc_src=1, br_target=0x100; following cycle pc_src=0.
//     BNE with alu_zero=1 -> pc_src=0.
//  T3 ADD 0x7FFF_FFFF_FFFF_FFFF+1, trap_en=1, pc=0x40 -> mem_valid=0, exc_pending=1, exc_pc=0x40,
//     exc_value=0x8000_0000_0000_0000, ovf_cnt=1.
//  T4 T3 then a second overflow at pc=0x44 before exc_ack -> exc_pc stays 0x40, ovf_cnt=1, bubbles;
//     exc_ack -> exc_pending=0 next cycle.
//  T5 taken branch captured, then stall=1 for 3 cycles -> mem_* hold, pc_src high only in the capture cycle.
//  T6 stall=1 and flush=1 together with valid ADD -> bubble, instr_cnt unchanged.
//     Counter preset near 2^CNT_W-1 -> wraps to 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: one-cycle capture of the ALU result and EX control, BEQ/BNE resolution,
// a sticky overflow exception with PC/value capture, and instruction/overflow performance counters.
module ex_mem_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  ex_trap_en,
  input  logic [XLEN-1:0]       ex_rs2_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_branch,
  input  logic                  ex_branch_ne,
  input  logic [XLEN-1:0]       ex_br_target,
  input  logic                  exc_ack,
  output logic                  mem_valid,
  output logic [XLEN-1:0]       mem_pc,
  output logic [XLEN-1:0]       mem_alu_result,
  output logic [XLEN-1:0]       mem_store_data,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic                  pc_src,
  output logic [XLEN-1:0]       br_target,
  output logic                  exc_pending,
  output logic [XLEN-1:0]       exc_pc,
  output logic [XLEN-1:0]       exc_value,
  output logic [CNT_W-1:0]      instr_cnt,
  output logic [CNT_W-1:0]      ovf_cnt
);

  typedef enum logic {ST_NORMAL = 1'b0, ST_EXC = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       res_q, res_d;
  logic [XLEN-1:0]       sdata_q, sdata_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  mr_q, mr_d;
  logic                  mw_q, mw_d;
  logic                  m2r_q, m2r_d;
  logic                  pc_src_q, pc_src_d;
  logic [XLEN-1:0]       br_tgt_q, br_tgt_d;
  logic                  exc_q, exc_d;
  logic [XLEN-1:0]       exc_pc_q, exc_pc_d;
  logic [XLEN-1:0]       exc_val_q, exc_val_d;
  logic [CNT_W-1:0]      icnt_q, icnt_d;
  logic [CNT_W-1:0]      ocnt_q, ocnt_d;

  logic take, trap, load, clear;

  assign take = ex_valid & ex_branch & (alu_zero ^ ex_branch_ne);
  assign trap = ex_valid & ex_trap_en & alu_overflow;

  always_comb begin
    state_d   = state_q;
    exc_d     = exc_q;
    exc_pc_d  = exc_pc_q;
    exc_val_d = exc_val_q;
    icnt_d    = icnt_q;
    ocnt_d    = ocnt_q;
    br_tgt_d  = br_tgt_q;
    pc_src_d  = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;

    // Acknowledge is independent of flush/stall; it only matters while an exception is pending.
    if (state_q == ST_EXC && exc_ack) begin
      state_d = ST_NORMAL;
      exc_d   = 1'b0;
    end

    if (flush) begin
      clear = 1'b1;
    end else if (stall) begin
      clear = 1'b0;
    end else if (state_q == ST_EXC) begin
      clear = 1'b1;
    end else if (trap) begin
      clear     = 1'b1;
      exc_d     = 1'b1;
      exc_pc_d  = ex_pc;
      exc_val_d = alu_result;
      ocnt_d    = ocnt_q + CNT_W'(1);
      state_d   = ST_EXC;
    end else if (ex_valid) begin
      load     = 1'b1;
      icnt_d   = icnt_q + CNT_W'(1);
      pc_src_d = take;
      br_tgt_d = ex_br_target;
    end else begin
      clear = 1'b1;
    end

    valid_d = valid_q;
    pc_d    = pc_q;
    res_d   = res_q;
    sdata_d = sdata_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    m2r_d   = m2r_q;
    if (clear) begin
      valid_d = 1'b0;
      pc_d    = '0;
      res_d   = '0;
      sdata_d = '0;
      rd_d    = '0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      m2r_d   = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = ex_pc;
      res_d   = alu_result;
      sdata_d = ex_rs2_data;
      rd_d    = ex_rd;
      rw_d    = ex_reg_write;
      mr_d    = ex_mem_read;
      mw_d    = ex_mem_write;
      m2r_d   = ex_mem_to_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_NORMAL;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      res_q     <= '0;
      sdata_q   <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      pc_src_q  <= 1'b0;
      br_tgt_q  <= '0;
      exc_q     <= 1'b0;
      exc_pc_q  <= '0;
      exc_val_q <= '0;
      icnt_q    <= '0;
      ocnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      res_q     <= res_d;
      sdata_q   <= sdata_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      mr_q      <= mr_d;
      mw_q      <= mw_d;
      m2r_q     <= m2r_d;
      pc_src_q  <= pc_src_d;
      br_tgt_q  <= br_tgt_d;
      exc_q     <= exc_d;
      exc_pc_q  <= exc_pc_d;
      exc_val_q <= exc_val_d;
      icnt_q    <= icnt_d;
      ocnt_q    <= ocnt_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_pc         = pc_q;
  assign mem_alu_result = res_q;
  assign mem_store_data = sdata_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = rw_q;
  assign mem_mem_read   = mr_q;
  assign mem_mem_write  = mw_q;
  assign mem_mem_to_reg = m2r_q;
  assign pc_src         = pc_src_q;
  assign br_target      = br_tgt_q;
  assign exc_pending    = exc_q;
  assign exc_pc         = exc_pc_q;
  assign exc_value      = exc_val_q;
  assign instr_cnt      = icnt_q;
  assign ovf_cnt        = ocnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus randomized traffic against a rule-level reference model.
module tb_ex_mem_stage;
  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall, flush, ex_valid, alu_zero, alu_overflow, ex_trap_en;
  logic [XLEN-1:0] ex_pc, alu_result, ex_rs2_data, ex_br_target;
  logic [RW-1:0] ex_rd;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_branch_ne, exc_ack;
  logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, pc_src, exc_pending;
  logic [XLEN-1:0] mem_pc, mem_alu_result, mem_store_data, br_target, exc_pc, exc_value;
  logic [RW-1:0] mem_rd;
  logic [CW-1:0] instr_cnt, ovf_cnt;

  ex_mem_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .ex_trap_en(ex_trap_en), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne),
    .ex_br_target(ex_br_target), .exc_ack(exc_ack), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .pc_src(pc_src), .br_target(br_target),
    .exc_pending(exc_pending), .exc_pc(exc_pc), .exc_value(exc_value),
    .instr_cnt(instr_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: what each output should read after the latest edge.
  logic m_valid, m_rw, m_mr, m_mw, m_m2r, m_pcsrc, m_exc;
  logic [XLEN-1:0] m_pc, m_res, m_sd, m_brt, m_epc, m_eval;
  logic [RW-1:0] m_rd;
  logic [CW-1:0] m_icnt, m_ocnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    {m_valid, m_rw, m_mr, m_mw, m_m2r, m_pcsrc, m_exc} = '0;
    m_pc = '0; m_res = '0; m_sd = '0; m_brt = '0; m_epc = '0; m_eval = '0;
    m_rd = '0; m_icnt = '0; m_ocnt = '0;
  endtask

  task automatic model_bubble();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
    m_pc = '0; m_res = '0; m_sd = '0; m_rd = '0;
  endtask

  task automatic model_edge();
    bit take, trap, was_exc;
    take    = ex_valid && ex_branch && (alu_zero != ex_branch_ne);
    trap    = ex_valid && ex_trap_en && alu_overflow;
    was_exc = m_exc;
    m_pcsrc = 0;
    if (flush) model_bubble();
    else if (stall) begin end
    else if (was_exc) model_bubble();
    else if (trap) begin
      model_bubble();
      m_exc = 1; m_epc = ex_pc; m_eval = alu_result; m_ocnt = m_ocnt + 1;
    end else if (ex_valid) begin
      m_valid = 1; m_pc = ex_pc; m_res = alu_result; m_sd = ex_rs2_data; m_rd = ex_rd;
      m_rw = ex_reg_write; m_mr = ex_mem_read; m_mw = ex_mem_write; m_m2r = ex_mem_to_reg;
      m_icnt = m_icnt + 1; m_pcsrc = take; m_brt = ex_br_target;
    end else model_bubble();
    if (was_exc && exc_ack) m_exc = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".mem_valid"}, 64'(mem_valid), 64'(m_valid));
    chk({ph, ".mem_pc"}, mem_pc, m_pc);
    chk({ph, ".mem_alu_result"}, mem_alu_result, m_res);
    chk({ph, ".mem_store_data"}, mem_store_data, m_sd);
    chk({ph, ".mem_rd"}, 64'(mem_rd), 64'(m_rd));
    chk({ph, ".mem_ctrl"}, 64'({mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}),
        64'({m_rw, m_mr, m_mw, m_m2r}));
    chk({ph, ".pc_src"}, 64'(pc_src), 64'(m_pcsrc));
    if (m_pcsrc) chk({ph, ".br_target"}, br_target, m_brt);
    chk({ph, ".exc_pending"}, 64'(exc_pending), 64'(m_exc));
    chk({ph, ".exc_pc"}, exc_pc, m_epc);
    chk({ph, ".exc_value"}, exc_value, m_eval);
    chk({ph, ".instr_cnt"}, 64'(instr_cnt), 64'(m_icnt));
    chk({ph, ".ovf_cnt"}, 64'(ovf_cnt), 64'(m_ocnt));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic idle();
    stall = 0; flush = 0; ex_valid = 0; alu_zero = 0; alu_overflow = 0; ex_trap_en = 0;
    ex_pc = '0; alu_result = '0; ex_rs2_data = '0; ex_br_target = '0; ex_rd = '0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    ex_branch = 0; ex_branch_ne = 0; exc_ack = 0;
  endtask

  task automatic alu_op(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] res);
    idle();
    ex_valid = 1; ex_pc = pc; alu_result = res; ex_rd = 5'd3; ex_reg_write = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst.mem_valid", 64'(mem_valid), 64'd0);
    chk("rst.instr_cnt", 64'(instr_cnt), 64'd0);
    chk("rst.ovf_cnt", 64'(ovf_cnt), 64'd0);
    chk("rst.pc_src", 64'(pc_src), 64'd0);
    chk("rst.exc_pending", 64'(exc_pending), 64'd0);
    chk("rst.mem_alu_result", mem_alu_result, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    idle();
    model_reset();
    #12 rst = 0;
    #1 check_all("init");

    // T1: reset asserted between edges while a valid entry is held
    alu_op(64'h10, 64'h1234);
    step("t1a");
    do_reset();
    check_all("t1b");

    // T2: BEQ taken, pulse lasts one cycle; BNE with zero=1 not taken
    alu_op(64'h20, 64'h0); ex_reg_write = 0; ex_branch = 1; alu_zero = 1; ex_br_target = 64'h100;
    step("t2a");
    chk("t2.pc_src_taken", 64'(pc_src), 64'd1);
    chk("t2.br_target", br_target, 64'h100);
    idle();
    step("t2b");
    chk("t2.pc_src_drop", 64'(pc_src), 64'd0);
    alu_op(64'h24, 64'h0); ex_branch = 1; ex_branch_ne = 1; alu_zero = 1; ex_br_target = 64'h200;
    step("t2c");
    chk("t2.bne_not_taken", 64'(pc_src), 64'd0);

    // T3/T4: overflow trap, second fault ignored, then acknowledge
    do_reset();
    alu_op(64'h40, 64'h8000_0000_0000_0000); alu_overflow = 1; ex_trap_en = 1;
    step("t3");
    chk("t3.mem_valid", 64'(mem_valid), 64'd0);
    chk("t3.exc_pending", 64'(exc_pending), 64'd1);
    chk("t3.exc_pc", exc_pc, 64'h40);
    chk("t3.exc_value", exc_value, 64'h8000_0000_0000_0000);
    chk("t3.ovf_cnt", 64'(ovf_cnt), 64'd1);
    alu_op(64'h44, 64'h9999); alu_overflow = 1; ex_trap_en = 1;
    step("t4a");
    chk("t4.exc_pc_kept", exc_pc, 64'h40);
    chk("t4.ovf_cnt_kept", 64'(ovf_cnt), 64'd1);
    chk("t4.bubble", 64'(mem_valid), 64'd0);
    idle(); exc_ack = 1;
    step("t4b");
    chk("t4.ack_clears", 64'(exc_pending), 64'd0);
    chk("t4.exc_pc_hold", exc_pc, 64'h40);
    idle();
    alu_op(64'h48, 64'h7); alu_overflow = 1;
    step("t4c");
    chk("t4.non_trap_ovf_captured", mem_alu_result, 64'h7);

    // T5: taken branch then three stall cycles
    alu_op(64'h50, 64'h0); ex_branch = 1; alu_zero = 1; ex_br_target = 64'h300;
    step("t5a");
    chk("t5.pc_src_capture", 64'(pc_src), 64'd1);
    alu_op(64'h54, 64'h55); stall = 1;
    for (int i = 0; i < 3; i++) begin
      step("t5s");
      chk("t5.pc_src_stalled", 64'(pc_src), 64'd0);
      chk("t5.mem_pc_held", mem_pc, 64'h50);
    end

    // T6: stall and flush together with a valid ADD
    alu_op(64'h60, 64'h66); stall = 1; flush = 1;
    step("t6a");
    chk("t6.bubble", 64'(mem_valid), 64'd0);
    chk("t6.instr_cnt", 64'(instr_cnt), 64'(m_icnt));

    // Counter wrap at 2^CNT_W
    do_reset();
    for (int i = 0; i < 255; i++) begin
      alu_op(64'(i * 4), 64'(i));
      step("wrap");
    end
    chk("wrap.at_max", 64'(instr_cnt), 64'd255);
    alu_op(64'h400, 64'h1);
    step("wrap_last");
    chk("wrap.to_zero", 64'(instr_cnt), 64'd0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      ex_valid      = ($urandom_range(0, 9) < 8);
      stall         = ($urandom_range(0, 99) < 15);
      flush         = ($urandom_range(0, 99) < 8);
      exc_ack       = ($urandom_range(0, 99) < 20);
      ex_trap_en    = $urandom_range(0, 1);
      alu_overflow  = ($urandom_range(0, 99) < 15);
      alu_zero      = $urandom_range(0, 1);
      ex_branch     = ($urandom_range(0, 99) < 30);
      ex_branch_ne  = $urandom_range(0, 1);
      ex_pc         = {$urandom, $urandom};
      alu_result    = {$urandom, $urandom};
      ex_rs2_data   = {$urandom, $urandom};
      ex_br_target  = {$urandom, $urandom};
      ex_rd         = RW'($urandom);
      {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} = 4'($urandom);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
